mem_fill_arbiter: RTL

- Owns the single main-memory port shared by the I-cache and D-cache.
- Arbitrates between three sources: I-cache miss fills, D-cache miss fills, and D-cache write-through stores.
- For each fill it sequences 8 word reads (one 16-byte block) and streams the returned words into the requesting cache's data array.
- Sits between the cache controller's miss logic and the main memory model; its busy/done outputs drive pipeline stall release.

---
 rtl/mem_fill_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter: shares one main-memory port between I/D block fills and
// D-cache write-through stores; streams returned fill words into the caches.
module mem_fill_arbiter #(
   parameter int MEM_LATENCY = 4,
   parameter int WORDS       = 8,
   parameter int ADDR_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              icache_miss,
   input  logic [ADDR_W-1:0] icache_miss_addr,
   input  logic              dcache_miss,
   input  logic [ADDR_W-1:0] dcache_miss_addr,
   input  logic              dcache_wr_req,
   input  logic [ADDR_W-1:0] dcache_wr_addr,
   input  logic [15:0]       dcache_wr_data,
   output logic              dcache_wr_ack,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic [15:0]       mem_rdata,
   input  logic              mem_rvalid,
   output logic [15:0]       fill_data,
   output logic [2:0]        fill_word,
   output logic              icache_fill_we,
   output logic              dcache_fill_we,
   output logic              icache_fill_done,
   output logic              dcache_fill_done,
   output logic              busy
);
   localparam int CW = $clog2(WORDS) + 1;

   if (WORDS != 8 || MEM_LATENCY < 1) begin : g_param_chk
      $error("mem_fill_arbiter: WORDS must be 8 and MEM_LATENCY >= 1");
   end

   typedef enum logic [1:0] {IDLE, WRITE, FILL, DONE} state_t;

   state_t            state_q;
   logic [CW-1:0]     issue_q, recv_q;
   logic              tgt_q;
   logic [ADDR_W-1:0] base_q, base_d;
   logic              grant_d, fill_ok;
   logic              mem_en_q, mem_wr_q, ack_q, idone_q, ddone_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [15:0]       mem_wdata_q;

   // tgt_q doubles as last_grant: 0 = I-cache, 1 = D-cache
   assign grant_d = dcache_miss && (!icache_miss || !tgt_q);
   assign base_d  = (grant_d ? dcache_miss_addr : icache_miss_addr) & ~ADDR_W'(2 * WORDS - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         issue_q     <= '0;
         recv_q      <= '0;
         tgt_q       <= 1'b0;
         base_q      <= '0;
         mem_en_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         ack_q       <= 1'b0;
         idone_q     <= 1'b0;
         ddone_q     <= 1'b0;
      end else begin
         mem_en_q <= 1'b0;
         mem_wr_q <= 1'b0;
         ack_q    <= 1'b0;
         idone_q  <= 1'b0;
         ddone_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (dcache_wr_req) begin
                  state_q     <= WRITE;
                  mem_en_q    <= 1'b1;
                  mem_wr_q    <= 1'b1;
                  mem_addr_q  <= dcache_wr_addr & ~ADDR_W'(1);
                  mem_wdata_q <= dcache_wr_data;
                  ack_q       <= 1'b1;
               end else if (dcache_miss || icache_miss) begin
                  state_q    <= FILL;
                  tgt_q      <= grant_d;
                  base_q     <= base_d;
                  mem_en_q   <= 1'b1;
                  mem_addr_q <= base_d;
                  issue_q    <= CW'(1);
               end
            end
            WRITE: state_q <= IDLE;
            FILL: begin
               if (issue_q < CW'(WORDS)) begin
                  mem_en_q   <= 1'b1;
                  mem_addr_q <= base_q | ADDR_W'({issue_q[CW-2:0], 1'b0});
                  issue_q    <= issue_q + 1'b1;
               end
               if (mem_rvalid) begin
                  recv_q <= recv_q + 1'b1;
                  if (recv_q == CW'(WORDS - 1)) begin
                     state_q <= DONE;
                     idone_q <= !tgt_q;
                     ddone_q <= tgt_q;
                  end
               end
            end
            default: begin
               issue_q <= '0;
               recv_q  <= '0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign fill_ok          = (state_q == FILL) && mem_rvalid;
   assign icache_fill_we   = fill_ok && !tgt_q;
   assign dcache_fill_we   = fill_ok && tgt_q;
   assign fill_data        = fill_ok ? mem_rdata : 16'h0;
   assign fill_word        = recv_q[CW-2:0];
   assign busy             = state_q != IDLE;
   assign mem_en           = mem_en_q;
   assign mem_wr           = mem_wr_q;
   assign mem_addr         = mem_addr_q;
   assign mem_wdata        = mem_wdata_q;
   assign dcache_wr_ack    = ack_q;
   assign icache_fill_done = idone_q;
   assign dcache_fill_done = ddone_q;
endmodule
